// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// publishing diff/bout/overflow only when a full result is available.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;

  logic             accept, last, d_bit, br_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign accept  = start && (state_q != SHIFT);
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_nxt = {d_bit, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      br_d   = bin;
      cnt_d  = '0;
      amsb_d = a[WIDTH-1];
      bmsb_d = b[WIDTH-1];
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_nxt;
      res_d = res_nxt;
      cnt_d = cnt_q + CW'(1);
      // Publish on the final bit so the outputs are valid during DONE.
      if (last) begin
        diff_d = res_nxt;
        bout_d = br_nxt;
        ovf_d  = (amsb_q != bmsb_q) && (d_bit != amsb_q);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction.
REQ-005 SHALL have port a, input, WIDTH, minuend, sampled only when a start is accepted.
REQ-006 SHALL have port b, input, WIDTH, subtrahend, sampled only when a start is accepted.
REQ-007 SHALL have port bin, input, 1, borrow-in, sampled only when a start is accepted.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a new valid result.
REQ-010 SHALL have port diff, output, WIDTH, result a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1, borrow-out: 1 iff a < b + bin, unsigned.
REQ-012 SHALL have port overflow, output, 1, two's-complement overflow of a - b - bin.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance it captures a, b and bin, sets the borrow flop to bin, clears the bit counter, and enters SHIFT.
REQ-015 SHALL ignore start while in SHIFT, without disturbing the operation in progress.
REQ-016 SHALL process exactly one bit per SHIFT cycle, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-017 SHALL, in each SHIFT cycle, shift the operand registers right by one and shift d into the MSB of the internal result shift register.
REQ-018 SHALL leave SHIFT after exactly WIDTH cycles, entering DONE; it then copies the internal result to diff, the final borrow to bout, and the overflow to overflow.
REQ-019 SHALL compute overflow as (a_msb != b_msb) && (result_msb != a_msb), using the MSBs captured at start.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE; DONE goes to IDLE, or to SHIFT if start is high in that cycle.
REQ-021 SHALL assert busy whenever the state is SHIFT, and only then.
REQ-022 Latency: if start is accepted at clock edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-023 SHALL hold diff, bout and overflow stable from one DONE to the next; partial results SHALL never appear on these outputs.
REQ-024 A start accepted in DONE SHALL begin a new operation with no idle cycle, and the just-completed result SHALL remain visible on the outputs.

Reset
REQ-025 Asserting reset SHALL, immediately and regardless of clock, force state IDLE and busy=0, done=0, diff=0, bout=0, overflow=0, and clear the counter, borrow flop and shift registers.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-027 The first accepted start after reset is released SHALL operate normally.

Verification (WIDTH=4)
REQ-028 a=7, b=3, bin=0, start pulse -> after 4 busy cycles, done=1, diff=4, bout=0, overflow=0.
REQ-029 a=3, b=7, bin=0 -> diff=12, bout=1, overflow=0; a=8, b=1, bin=0 -> diff=7, bout=0, overflow=1.
REQ-030 a=0, b=0, bin=1 -> diff=15, bout=1, overflow=0.
REQ-031 start pulsed again on the 2nd busy cycle with different operands -> ignored; the original result is delivered on time.
REQ-032 reset pulsed on the 2nd busy cycle -> all outputs 0 at once, no done pulse; a following start with a=5, b=2 yields diff=3.
REQ-033 start held high continuously with a=9, b=4 -> done pulses every 5 cycles, each with diff=5, and busy=0 only during the DONE cycles.
